// File: rtl/load_store_unit_if.sv
// Pipeline-side request/response and data-memory strobe signals of the load/store unit.
// master = pipeline plus memory model, slave = load_store_unit.
interface load_store_unit_if;
  logic        req;
  logic [3:0]  op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        err;
  logic [31:0] rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] mem_rdata;

  modport master (
    output req, op, addr, wdata, mem_rdata,
    input  busy, done, err, rdata, mem_addr, mem_wdata, mem_read, mem_write
  );

  modport slave (
    input  req, op, addr, wdata, mem_rdata,
    output busy, done, err, rdata, mem_addr, mem_wdata, mem_read, mem_write
  );
endinterface

// File: rtl/load_store_unit.sv
// Byte/half/word load-store engine; done 2 cycles after accept (sub-word store 3, reject 1).
// Pipeline stalls on busy; requests seen while busy are dropped.
module load_store_unit #(
  parameter int MEM_BYTES = 65536
) (
  input logic               clk,
  input logic               rst,
  load_store_unit_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RD, WR, DONE} state_t;

  localparam logic [32:0] LIMIT = 33'(MEM_BYTES);

  state_t      state;
  logic        store_q;
  logic [2:0]  f3_q;
  logic [1:0]  lane_q;
  logic [15:0] wdata_q;

  logic        is_store;
  logic [2:0]  f3;
  logic        bad_op;
  logic        misaligned;
  logic        out_of_range;
  logic        reject;

  always_comb begin
    is_store     = bus.op[3];
    f3           = bus.op[2:0];
    bad_op       = is_store ? !(f3 inside {3'b000, 3'b001, 3'b010})
                            :  (f3 inside {3'b011, 3'b110, 3'b111});
    misaligned   = ((f3[1:0] == 2'b01) && bus.addr[0]) ||
                   ((f3[1:0] == 2'b10) && (bus.addr[1:0] != 2'b00));
    out_of_range = ({1'b0, bus.addr} >= LIMIT);
    reject       = bad_op || misaligned || out_of_range;
  end

  // f[1]: word, f[0]: half, f[2]: zero-extend.
  function automatic logic [31:0] extract(input logic [31:0] w, input logic [2:0] f,
                                          input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    case (lane)
      2'd0:    b = w[7:0];
      2'd1:    b = w[15:8];
      2'd2:    b = w[23:16];
      default: b = w[31:24];
    endcase
    h = lane[1] ? w[31:16] : w[15:0];
    if (f[1])      return w;
    else if (f[0]) return {{16{h[15] & ~f[2]}}, h};
    else           return {{24{b[7] & ~f[2]}}, b};
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] w, input logic [2:0] f,
                                        input logic [1:0] lane, input logic [15:0] d);
    logic [31:0] r;
    r = w;
    if (f[0]) begin
      if (lane[1]) r[31:16] = d;
      else         r[15:0]  = d;
    end else begin
      case (lane)
        2'd0:    r[7:0]   = d[7:0];
        2'd1:    r[15:8]  = d[7:0];
        2'd2:    r[23:16] = d[7:0];
        default: r[31:24] = d[7:0];
      endcase
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      store_q       <= 1'b0;
      f3_q          <= 3'b000;
      lane_q        <= 2'b00;
      wdata_q       <= 16'h0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.err       <= 1'b0;
      bus.rdata     <= 32'h0;
      bus.mem_addr  <= 32'h0;
      bus.mem_wdata <= 32'h0;
      bus.mem_read  <= 1'b0;
      bus.mem_write <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req) begin
            store_q  <= is_store;
            f3_q     <= f3;
            lane_q   <= bus.addr[1:0];
            wdata_q  <= bus.wdata[15:0];
            bus.busy <= 1'b1;
            if (reject) begin
              bus.done <= 1'b1;
              bus.err  <= 1'b1;
              state    <= DONE;
            end else begin
              bus.mem_addr <= {bus.addr[31:2], 2'b00};
              if (is_store && (f3[1:0] == 2'b10)) begin
                bus.mem_wdata <= bus.wdata;
                bus.mem_write <= 1'b1;
                state         <= WR;
              end else begin
                // Sub-word stores also read first so untouched lanes survive.
                bus.mem_read <= 1'b1;
                state        <= RD;
              end
            end
          end
        end
        RD: begin
          bus.mem_read <= 1'b0;
          if (store_q) begin
            bus.mem_wdata <= merge(bus.mem_rdata, f3_q, lane_q, wdata_q);
            bus.mem_write <= 1'b1;
            state         <= WR;
          end else begin
            bus.rdata <= extract(bus.mem_rdata, f3_q, lane_q);
            bus.done  <= 1'b1;
            state     <= DONE;
          end
        end
        WR: begin
          bus.mem_write <= 1'b0;
          bus.done      <= 1'b1;
          state         <= DONE;
        end
        DONE: begin
          bus.done <= 1'b0;
          bus.err  <= 1'b0;
          bus.busy <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: per-cycle schedule model plus literal spot checks.
module tb_load_store_unit;
  localparam int MEM_BYTES = 65536;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  load_store_unit_if bus();

  load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem     [16384];
  logic [31:0] ref_mem [16384];

  assign bus.mem_rdata = mem[bus.mem_addr[15:2]];
  always @(posedge clk) if (bus.mem_write) mem[bus.mem_addr[15:2]] <= bus.mem_wdata;

  typedef struct {
    logic        busy, done, err, rd, wr;
    logic [31:0] rdata, maddr, wdat;
  } cyc_t;

  cyc_t        sched[$];
  logic [31:0] model_rdata = 32'h0;
  int          n_checks = 0;
  int          n_fail = 0;
  bit          run_cmp = 1'b0;
  cyc_t        popped;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit rejected(input logic [3:0] op, input logic [31:0] a);
    int size;
    case (op[2:0])
      3'd0, 3'd4: size = 1;
      3'd1, 3'd5: size = 2;
      3'd2:       size = 4;
      default:    size = 0;
    endcase
    if (size == 0 || (op[3] && op[2])) return 1'b1;
    return ((a % size) != 0) || (a >= MEM_BYTES);
  endfunction

  function automatic logic [31:0] ld_val(input logic [31:0] word, input logic [2:0] f3,
                                         input logic [31:0] a);
    logic [31:0] v;
    case (f3)
      3'd0: begin v = (word >> (8 * a[1:0])) & 32'hFF;   if (v >= 128)   v = v - 256;   end
      3'd4:       v = (word >> (8 * a[1:0])) & 32'hFF;
      3'd1: begin v = (word >> (16 * a[1])) & 32'hFFFF;  if (v >= 32768) v = v - 65536; end
      3'd5:       v = (word >> (16 * a[1])) & 32'hFFFF;
      default:    v = word;
    endcase
    return v;
  endfunction

  function automatic logic [31:0] st_word(input logic [31:0] word, input logic [2:0] f3,
                                          input logic [31:0] a, input logic [31:0] w);
    int          sh;
    logic [31:0] mask;
    sh   = f3[0] ? 16 * a[1] : 8 * a[1:0];
    mask = f3[0] ? 32'hFFFF : 32'hFF;
    return (word & ~(mask << sh)) | ((w & mask) << sh);
  endfunction

  // Builds the cycle-by-cycle outputs a freshly accepted request must produce.
  task automatic plan(input logic [3:0] op, input logic [31:0] a, input logic [31:0] w);
    cyc_t c;
    c = '{busy: 1'b1, done: 1'b0, err: 1'b0, rd: 1'b0, wr: 1'b0,
          rdata: model_rdata, maddr: {a[31:2], 2'b00}, wdat: 32'h0};
    if (rejected(op, a)) begin
      c.done = 1'b1; c.err = 1'b1; sched.push_back(c);
    end else if (!op[3]) begin
      c.rd = 1'b1; sched.push_back(c);
      c.rd = 1'b0; c.done = 1'b1; c.rdata = ld_val(ref_mem[a[15:2]], op[2:0], a);
      sched.push_back(c);
    end else if (op[2:0] == 3'd2) begin
      c.wr = 1'b1; c.wdat = w; sched.push_back(c);
      c.wr = 1'b0; c.done = 1'b1; sched.push_back(c);
    end else begin
      c.rd = 1'b1; sched.push_back(c);
      c.rd = 1'b0; c.wr = 1'b1; c.wdat = st_word(ref_mem[a[15:2]], op[2:0], a, w);
      sched.push_back(c);
      c.wr = 1'b0; c.done = 1'b1; sched.push_back(c);
    end
  endtask

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      sched.delete();
      model_rdata = 32'h0;
    end else if (sched.size() == 0) begin
      if (bus.req) plan(bus.op, bus.addr, bus.wdata);
    end else begin
      popped = sched.pop_front();
      model_rdata = popped.rdata;
      if (popped.wr) ref_mem[popped.maddr[15:2]] = popped.wdat;
    end
  end

  logic prev_rd = 1'b0;
  logic prev_wr = 1'b0;
  always @(negedge clk) begin
    cyc_t e;
    if (run_cmp) begin
      if (sched.size() > 0) e = sched[0];
      else e = '{busy: 1'b0, done: 1'b0, err: 1'b0, rd: 1'b0, wr: 1'b0,
                 rdata: model_rdata, maddr: 32'h0, wdat: 32'h0};
      chk("busy", bus.busy, e.busy);
      chk("done", bus.done, e.done);
      chk("err", bus.err, e.err);
      chk("rdata", bus.rdata, e.rdata);
      chk("mem_read", bus.mem_read, e.rd);
      chk("mem_write", bus.mem_write, e.wr);
      if (e.rd || e.wr) chk("mem_addr", bus.mem_addr, e.maddr);
      if (e.wr) chk("mem_wdata", bus.mem_wdata, e.wdat);
      if (bus.mem_read) chk("read_fresh_edge", prev_rd, 1'b0);
      if (bus.mem_write) chk("write_fresh_edge", prev_wr, 1'b0);
      prev_rd = bus.mem_read;
      prev_wr = bus.mem_write;
    end
  end

  task automatic wait_idle(input string name);
    @(posedge clk); #1;
    for (int i = 0; i < 20 && bus.busy; i++) begin @(posedge clk); #1; end
    if (bus.busy) chk({name, " idle_timeout"}, 32'd1, 32'd0);
  endtask

  task automatic issue(input string name, input logic [3:0] op, input logic [31:0] a,
                       input logic [31:0] w, input int exp_lat, input logic exp_err,
                       input logic [31:0] exp_rd);
    int lat;
    wait_idle(name);
    bus.req = 1'b1; bus.op = op; bus.addr = a; bus.wdata = w;
    @(posedge clk); #1;
    bus.req = 1'b0;
    lat = 1;
    while (!bus.done && lat < 8) begin @(posedge clk); #1; lat++; end
    chk({name, " latency"}, lat, exp_lat);
    chk({name, " err"}, bus.err, exp_err);
    chk({name, " rdata"}, bus.rdata, exp_rd);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 16384; i++) begin mem[i] = 32'h0; ref_mem[i] = 32'h0; end
    mem[0] = 32'h8081_7F01; ref_mem[0] = 32'h8081_7F01;
    mem[1] = 32'h1122_3344; ref_mem[1] = 32'h1122_3344;
    bus.req = 1'b0; bus.op = 4'h0; bus.addr = 32'h0; bus.wdata = 32'h0;

    #2 rst = 1'b0;
    #1 run_cmp = 1'b1;
    chk("reset busy", bus.busy, 0);
    chk("reset done", bus.done, 0);
    chk("reset err", bus.err, 0);
    chk("reset mem_read", bus.mem_read, 0);
    chk("reset mem_write", bus.mem_write, 0);
    chk("reset rdata", bus.rdata, 0);
    chk("reset mem_addr", bus.mem_addr, 0);
    chk("reset mem_wdata", bus.mem_wdata, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;

    issue("lw0",   4'b0010, 32'd0, 32'h0, 2, 1'b0, 32'h8081_7F01);
    issue("lb2",   4'b0000, 32'd2, 32'h0, 2, 1'b0, 32'hFFFF_FF81);
    issue("lbu2",  4'b0100, 32'd2, 32'h0, 2, 1'b0, 32'h0000_0081);
    issue("lh2",   4'b0001, 32'd2, 32'h0, 2, 1'b0, 32'hFFFF_8081);
    issue("lhu0",  4'b0101, 32'd0, 32'h0, 2, 1'b0, 32'h0000_7F01);
    issue("lb1",   4'b0000, 32'd1, 32'h0, 2, 1'b0, 32'h0000_007F);
    issue("sb5",   4'b1000, 32'd5, 32'hAB, 3, 1'b0, 32'h0000_007F);
    chk("sb5 memory word1", mem[1], 32'h1122_AB44);
    issue("sh6",   4'b1001, 32'd6, 32'hBEEF, 3, 1'b0, 32'h0000_007F);
    chk("sh6 memory word1", mem[1], 32'hBEEF_AB44);

    issue("lw_mis",   4'b0010, 32'd2, 32'h0, 1, 1'b1, 32'h0000_007F);
    issue("lh_mis",   4'b0001, 32'd1, 32'h0, 1, 1'b1, 32'h0000_007F);
    issue("sw_range", 4'b1010, 32'd65536, 32'h5, 1, 1'b1, 32'h0000_007F);
    issue("st_f3_4",  4'b1100, 32'd0, 32'h5, 1, 1'b1, 32'h0000_007F);
    issue("sw_top",   4'b1010, 32'd65532, 32'h1234_5678, 2, 1'b0, 32'h0000_007F);
    issue("lw_top",   4'b0010, 32'd65532, 32'h0, 2, 1'b0, 32'h1234_5678);
    issue("ld_f3_3",  4'b0011, 32'd0, 32'h0, 1, 1'b1, 32'h1234_5678);
    chk("word0 untouched", mem[0], 32'h8081_7F01);

    wait_idle("hs");
    bus.req = 1'b1; bus.op = 4'b1010; bus.addr = 32'd8; bus.wdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    bus.op = 4'b0010; bus.addr = 32'd0;
    @(posedge clk); #1;
    bus.req = 1'b0;
    chk("hs done", bus.done, 1);
    chk("hs err", bus.err, 0);
    @(posedge clk); #1;
    chk("hs ignored busy", bus.busy, 0);
    chk("hs ignored rdata", bus.rdata, 32'h1234_5678);
    chk("hs memory word2", mem[2], 32'hCAFE_F00D);
    issue("lw8_reissue", 4'b0010, 32'd8, 32'h0, 2, 1'b0, 32'hCAFE_F00D);

    wait_idle("rst_mid");
    bus.req = 1'b1; bus.op = 4'b1000; bus.addr = 32'd12; bus.wdata = 32'h55;
    @(posedge clk); #1;
    bus.req = 1'b0;
    @(posedge clk); #1;
    chk("rst_mid in WR", bus.mem_write, 1);
    #1 rst = 1'b0;
    #1;
    chk("rst_mid mem_write", bus.mem_write, 0);
    chk("rst_mid busy", bus.busy, 0);
    chk("rst_mid done", bus.done, 0);
    chk("rst_mid rdata", bus.rdata, 0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid word3 unwritten", mem[3], 32'h0);
    issue("lw0_after_rst", 4'b0010, 32'd0, 32'h0, 2, 1'b0, 32'h8081_7F01);

    @(posedge clk); #1;
    @(posedge clk); #1;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
- Sits between the EX/MEM pipeline register and the word-addressed data memory; the data memory is the downstream consumer of this block's strobes.
- Converts byte, halfword and word load/store requests into single-cycle read/write strobe pulses on that memory:
  - loads: lane extraction with sign or zero extension;
  - sub-word stores: read-modify-write.
- Flags misaligned, out-of-range and illegal requests without touching memory.
- Provides a busy/done handshake so the pipeline stalls while an access is in flight.

Parameters:
- MEM_BYTES, 65536, byte capacity of the data memory; any address >= MEM_BYTES is an error.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-low reset
- req  in  1  request strobe, sampled only in IDLE
- op  in  4  op[3]=store; op[2:0]=funct3: 000 byte, 001 half, 010 word, 100 byte-unsigned (load only), 101 half-unsigned (load only)
- addr  in  32  byte address
- wdata  in  32  store data; byte/half stores use the low bits
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle completion pulse
- err  out  1  valid with done; 1 = request rejected, no memory access made
- rdata  out  32  load result, extended to 32 bits; held until the next done
- mem_addr  out  32  word-aligned address {addr[31:2],2'b00}
- mem_wdata  out  32  full word to write
- mem_read  out  1  read strobe (registered)
- mem_write  out  1  write strobe (registered)
- mem_rdata  in  32  memory read word

Behaviour:
- Reset (asynchronous, rst=0):
  - State returns to IDLE immediately, including mid-operation; the aborted access is not completed.
  - busy, done, err, mem_read and mem_write are 0.
  - rdata, mem_addr and mem_wdata are 0.
- States: IDLE, RD, WR, DONE.
- IDLE, on req=1, the request is latched, then:
  - Error (→ DONE with err=1) if any of:
    - op is illegal: store with funct3 not in {000,001,010}, or load with funct3 in {011,110,111};
    - half access with addr[0]≠0;
    - word access with addr[1:0]≠0;
    - addr >= MEM_BYTES.
  - Otherwise → RD for loads, byte stores and half stores.
  - Otherwise → WR for word stores.
- RD:
  - mem_read=1 for exactly this cycle.
  - mem_rdata is captured at the closing edge.
  - Loads → DONE. rdata is formed from the captured word:
    - lane = addr[1:0]; byte k occupies bits [8k+7:8k] (little-endian);
    - a half uses lanes addr[1]*2 and addr[1]*2+1;
    - sign extension for funct3 000/001, zero extension for 100/101.
  - Byte/half stores → WR. mem_wdata is registered as the captured word with the addressed lane(s) replaced by wdata[7:0] or wdata[15:0].
- WR:
  - mem_write=1 for exactly this cycle, with mem_wdata stable from the cycle's start.
  - For word stores, mem_wdata = wdata.
  - → DONE.
- DONE:
  - done=1 for one cycle; err=1 only for rejected requests.
  - mem_read=mem_write=0.
  - → IDLE.
- Strobe guarantees:
  - mem_read and mem_write are never high in the same cycle.
  - Each strobe is preceded by at least one low cycle, so every access produces a fresh rising edge at the memory.
- Latency, counted as cycles from the accepting edge to the done cycle:
  - loads: 2
  - word stores: 2
  - byte/half stores: 3
  - errors: 1
- Handshake:
  - req while busy=1 is ignored. The pipeline holds its request until done; req may be reasserted in the cycle after done.
  - rdata is unchanged by stores and by errors.
- Boundaries:
  - addr = MEM_BYTES-4 with a word op is legal.
  - addr = MEM_BYTES with any op is an error.
  - addr bits above the range check are not masked.

Test Plan:
- Load word: memory word 0 = 32'h8081_7F01; LW addr 0 → mem_read pulses once; done 2 cycles after accept; rdata=32'h8081_7F01; err=0.
- Byte and half extension, same word:
  - LB addr 2 → 32'hFFFF_FF81; LBU addr 2 → 32'h0000_0081;
  - LH addr 2 → 32'hFFFF_8081; LHU addr 0 → 32'h0000_7F01;
  - LB addr 1 → 32'h0000_007F.
- Store byte RMW:
  - word 1 = 32'h1122_3344; SB addr 5, wdata=32'hAB → RD, WR, done after 3 cycles; memory word 1 = 32'h1122_AB44.
  - SH addr 6, wdata=32'hBEEF → memory word 1 = 32'hBEEF_AB44.
- Errors:
  - LW addr 2 → done+err next cycle; mem_read and mem_write never asserted.
  - LH addr 1 → err.
  - SW addr 65536 → err.
  - store op funct3 100 → err.
  - rdata unchanged in every case.
- Handshake/strobe: SW issued, then req pulsed during WR with LW addr 0 → second request ignored; a reissue after done succeeds; mem_write and mem_read each show a low cycle before going high.
- Reset mid-op: rst=0 during WR of an SB → mem_write drops immediately; busy=0 and state IDLE; the next LW after release completes normally.
